// File: rtl/mmio_ctrl.sv
// mmio_ctrl: Riscv151 memory-mapped I/O block -- UART TX FIFO / RX pop, status/control,
// cycle and retired-instruction counters. Load data is registered (1-cycle latency).
module mmio_ctrl #(
    parameter logic [3:0] MMIO_REGION = 4'b1000,
    parameter int         TX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic        inst_valid,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RX      = 8'h04;
    localparam logic [7:0] OFF_TX      = 8'h08;
    localparam logic [7:0] OFF_CYC     = 8'h10;
    localparam logic [7:0] OFF_INST    = 8'h14;
    localparam logic [7:0] OFF_CNT_CLR = 8'h18;

    logic        sel_s;
    logic [7:0]  off_s;
    logic        rd_s;
    logic        ctrl_wr_s;
    logic        tx_wr_s;
    logic        cnt_clr_s;
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        push_s;
    logic        ovf_set_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    logic [7:0]     tx_mem_r [TX_DEPTH];
    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;
    logic           ovf_r;
    logic [31:0]    cyc_cnt_r;
    logic [31:0]    inst_cnt_r;
    logic [31:0]    rdata_r;

    assign sel_s    = (addr[31:28] == MMIO_REGION);
    assign off_s    = addr[7:0];
    assign rd_s     = re && sel_s;
    assign unused_s = ^{addr[27:8], wdata[31:8]};

    // The extra wrap bit distinguishes full from empty when the index bits match.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign pop_s     = !empty_s && uart_tx_ready;
    assign push_s    = tx_wr_s && (!full_s || pop_s);
    assign ovf_set_s = tx_wr_s && full_s && !pop_s;

    assign uart_tx_valid = !empty_s;
    assign uart_tx_data  = tx_mem_r[rd_ptr_r[PTR_W-1:0]];
    assign uart_rx_ready = rd_s && (off_s == OFF_RX) && uart_rx_valid && !rst;
    assign rdata         = rdata_r;

    // Store decode: which register a store in this cycle targets.
    always_comb begin
        ctrl_wr_s = 1'b0;
        tx_wr_s   = 1'b0;
        cnt_clr_s = 1'b0;
        if (sel_s) begin
            case (off_s)
                OFF_STATUS:  ctrl_wr_s = we[0];
                OFF_TX:      tx_wr_s   = we[0];
                OFF_CNT_CLR: cnt_clr_s = (we != 4'b0000);
                default:     ctrl_wr_s = 1'b0;
            endcase
        end else begin
            ctrl_wr_s = 1'b0;
        end
    end

    // Load mux from pre-edge state; status reflects occupancy before this edge's push/pop.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (off_s)
            OFF_STATUS: rdata_s = {29'b0, ovf_r, uart_rx_valid, !full_s};
            OFF_RX:     rdata_s = uart_rx_valid ? {24'b0, uart_rx_data} : 32'h0000_0000;
            OFF_CYC:    rdata_s = cyc_cnt_r;
            OFF_INST:   rdata_s = inst_cnt_r;
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // TX FIFO storage (no reset needed: pointers define validity).
    always_ff @(posedge clk) begin
        if (push_s) begin
            tx_mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata[7:0];
        end
    end

    // TX FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Sticky overflow: a same-cycle overflow beats a software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ctrl_wr_s && wdata[2]) begin
            ovf_r <= 1'b0;
        end
    end

    // Free-running cycle counter; a counter-clear store wins over the increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr_s) begin
            cyc_cnt_r <= 32'h0000_0000;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
        end
    end

    // Retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr_s) begin
            inst_cnt_r <= 32'h0000_0000;
        end else if (inst_valid) begin
            inst_cnt_r <= inst_cnt_r + 32'd1;
        end
    end

    // Load data register: holds until the next selected load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_s) begin
            rdata_r <= rdata_s;
        end
    end

endmodule
